// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter: round-robin sharing of the data memory between two ports.
// Registered command stage drives memory; reads and errors answer two cycles after grant.
module mem_data_arbiter #(
   parameter int unsigned MEM_BYTES = 1 << 20,
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clk_enable,
   input  logic          i_req0,
   input  logic          i_req1,
   input  logic          i_we0,
   input  logic          i_we1,
   input  logic [AW-1:0] i_addr0,
   input  logic [AW-1:0] i_addr1,
   input  logic [DW-1:0] i_wdata0,
   input  logic [DW-1:0] i_wdata1,
   output logic          o_gnt0,
   output logic          o_gnt1,
   output logic          o_rvalid0,
   output logic          o_rvalid1,
   output logic [DW-1:0] o_rdata,
   output logic          o_err,
   output logic          o_mem_write,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_data,
   input  logic [DW-1:0] i_mem_data
);

   localparam logic [AW-1:0] LAST_WORD = AW'(MEM_BYTES - 32'd4);

   logic          rr_q, rr_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          cmd_id_q, cmd_id_d;
   logic          cmd_we_q, cmd_we_d;
   logic          cmd_err_q, cmd_err_d;
   logic [AW-1:0] cmd_addr_q, cmd_addr_d;
   logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
   logic          resp_valid_q, resp_valid_d;
   logic          resp_id_q, resp_id_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;

   logic          gnt0, gnt1, gnt_any;
   logic          sel_we, sel_err, rsp_fire;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Round-robin grant: rr_q names the port that wins when both request.
   always_comb begin
      gnt0      = i_clk_enable & i_req0 & (~i_req1 | ~rr_q);
      gnt1      = i_clk_enable & i_req1 & (~i_req0 | rr_q);
      gnt_any   = gnt0 | gnt1;
      sel_we    = gnt1 ? i_we1 : i_we0;
      sel_addr  = gnt1 ? i_addr1 : i_addr0;
      sel_wdata = gnt1 ? i_wdata1 : i_wdata0;
      sel_err   = (sel_addr[1:0] != 2'b00) | (sel_addr > LAST_WORD);
      rsp_fire  = cmd_valid_q & (~cmd_we_q | cmd_err_q);
   end

   // Next state for command and response stages; everything holds while disabled.
   always_comb begin
      rr_d         = rr_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_id_d     = cmd_id_q;
      cmd_we_d     = cmd_we_q;
      cmd_err_d    = cmd_err_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_wdata_d  = cmd_wdata_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      if (i_clk_enable) begin
         cmd_valid_d  = gnt_any;
         resp_valid_d = rsp_fire;
         if (gnt_any) begin
            rr_d        = ~gnt1;
            cmd_id_d    = gnt1;
            cmd_we_d    = sel_we;
            cmd_err_d   = sel_err;
            cmd_addr_d  = sel_addr;
            cmd_wdata_d = sel_wdata;
         end
         if (rsp_fire) begin
            resp_id_d = cmd_id_q;
            rdata_d   = cmd_err_q ? '0 : i_mem_data;
            err_d     = cmd_err_q;
         end
      end
   end

   // Pipeline registers; reset drops any in-flight command or response.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_q         <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_id_q     <= 1'b0;
         cmd_we_q     <= 1'b0;
         cmd_err_q    <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         rr_q         <= rr_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_id_q     <= cmd_id_d;
         cmd_we_q     <= cmd_we_d;
         cmd_err_q    <= cmd_err_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   // Output mapping; the write strobe is suppressed for errored commands.
   always_comb begin
      o_gnt0      = gnt0;
      o_gnt1      = gnt1;
      o_rvalid0   = resp_valid_q & ~resp_id_q;
      o_rvalid1   = resp_valid_q & resp_id_q;
      o_rdata     = rdata_q;
      o_err       = err_q;
      o_mem_addr  = cmd_addr_q;
      o_mem_data  = cmd_wdata_q;
      o_mem_write = cmd_valid_q & cmd_we_q & ~cmd_err_q & i_clk_enable;
   end

endmodule
